// File: rtl/ppa_pkg.sv
// Shared definitions for the shared-adder scheduler: widths, lock state and operand slicing.
package ppa_pkg;

  localparam int ADD_W   = 7;
  localparam int MAX_REQ = 8;
  localparam int IDX_W   = 3;

  typedef enum logic {
    LK_UNLOCKED = 1'b0,
    LK_LOCKED   = 1'b1
  } lock_state_e;

  // Extract requester idx's operand from a bus zero-extended to MAX_REQ slots.
  function automatic logic [ADD_W-1:0] op_slice(input logic [ADD_W*MAX_REQ-1:0] bus,
                                                input logic [IDX_W-1:0]         idx);
    return bus[idx*ADD_W +: ADD_W];
  endfunction

endpackage

// File: rtl/ppa_8.sv
// Kogge-Stone parallel-prefix adder, ADD_W bits wide; sum wraps, carry-out is dropped.
module ppa_8
  import ppa_pkg::*;
(
  input  logic [ADD_W-1:0] a_i,
  input  logic [ADD_W-1:0] b_i,
  input  logic             cin_i,
  output logic [ADD_W-1:0] sum_o
);

  logic [3:0][ADD_W-1:0] g_lv;
  logic [3:0][ADD_W-1:0] p_lv;
  logic [ADD_W-1:0]      carry;

  // Prefix tree over spans 1,2,4, then fold carry-in into every bit position.
  always_comb begin
    g_lv    = '0;
    p_lv    = '0;
    carry   = '0;
    g_lv[0] = a_i & b_i;
    p_lv[0] = a_i ^ b_i;
    for (int lv = 1; lv < 4; lv++) begin
      for (int i = 0; i < ADD_W; i++) begin
        if (i >= (1 << (lv - 1))) begin
          g_lv[lv][i] = g_lv[lv-1][i] | (p_lv[lv-1][i] & g_lv[lv-1][i - (1 << (lv - 1))]);
          p_lv[lv][i] = p_lv[lv-1][i] & p_lv[lv-1][i - (1 << (lv - 1))];
        end else begin
          g_lv[lv][i] = g_lv[lv-1][i];
          p_lv[lv][i] = p_lv[lv-1][i];
        end
      end
    end
    carry[0] = cin_i;
    for (int i = 1; i < ADD_W; i++) begin
      carry[i] = g_lv[3][i-1] | (p_lv[3][i-1] & cin_i);
    end
    sum_o = p_lv[0] ^ carry;
  end

endmodule

// File: rtl/ppa_rr_pick.sv
// Round-robin pick: first set bit of vec_i starting at ptr_i and wrapping modulo NREQ.
module ppa_rr_pick #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] vec_i,
  input  logic [IDW-1:0]  ptr_i,
  output logic [IDW-1:0]  idx_o,
  output logic            found_o
);

  logic [IDW-1:0] cand;

  // Scan from farthest to nearest so the nearest hit to ptr_i is the last one written.
  always_comb begin
    idx_o   = '0;
    found_o = 1'b0;
    cand    = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      cand = IDW'((int'(ptr_i) + k) % NREQ);
      if (vec_i[cand]) begin
        idx_o   = cand;
        found_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ppa_arb.sv
// Round-robin scheduler sharing one prefix adder among NREQ requesters, with locked bursts.
module ppa_arb
  import ppa_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int IDW      = $clog2(NREQ),
  parameter int LOCK_MAX = 15
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [ADD_W*NREQ-1:0] req_a,
  input  logic [ADD_W*NREQ-1:0] req_b,
  input  logic [NREQ-1:0]       req_cin,
  input  logic [NREQ-1:0]       req_lock,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [ADD_W-1:0]      rsp_sum,
  output logic [IDW-1:0]        rsp_id,
  output logic                  lock_err
);

  lock_state_e          lk_state_q, lk_state_d;
  logic [IDW-1:0]       owner_q, owner_d;
  logic [7:0]           idle_q, idle_d;
  logic [IDW-1:0]       ptr_q, ptr_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic [ADD_W-1:0]     rsp_sum_q, rsp_sum_d;
  logic [IDW-1:0]       rsp_id_q, rsp_id_d;
  logic                 lock_err_q, lock_err_d;

  logic [IDW-1:0]       rr_idx;
  logic                 rr_found;
  logic [IDW-1:0]       grant;
  logic                 found;
  logic                 can_issue;
  logic                 accept;
  logic [ADD_W*MAX_REQ-1:0] a_bus, b_bus;
  logic [ADD_W-1:0]     add_a, add_b, add_sum;
  logic                 add_cin;

  function automatic logic [IDW-1:0] wrap_inc(input logic [IDW-1:0] idx);
    return (int'(idx) == NREQ - 1) ? '0 : idx + 1'b1;
  endfunction

  ppa_rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
    .vec_i   (req_valid),
    .ptr_i   (ptr_q),
    .idx_o   (rr_idx),
    .found_o (rr_found)
  );

  // Grant: a held lock restricts eligibility to its owner, otherwise round-robin.
  always_comb begin
    if (lk_state_q == LK_LOCKED) begin
      grant = owner_q;
      found = req_valid[owner_q];
    end else begin
      grant = rr_idx;
      found = rr_found;
    end
  end

  assign can_issue = !rsp_valid_q || rsp_ready;
  assign accept    = found && can_issue;
  assign req_ready = accept ? (NREQ'(1) << grant) : '0;

  // Route the granted requester's operands to the shared adder.
  always_comb begin
    a_bus                   = '0;
    b_bus                   = '0;
    a_bus[ADD_W*NREQ-1:0]   = req_a;
    b_bus[ADD_W*NREQ-1:0]   = req_b;
  end

  assign add_a   = op_slice(a_bus, IDX_W'(grant));
  assign add_b   = op_slice(b_bus, IDX_W'(grant));
  assign add_cin = req_cin[grant];

  ppa_8 u_add (
    .a_i   (add_a),
    .b_i   (add_b),
    .cin_i (add_cin),
    .sum_o (add_sum)
  );

  // Lock FSM and priority pointer; an owner accept always beats a timeout in the same cycle.
  always_comb begin
    lk_state_d = lk_state_q;
    owner_d    = owner_q;
    idle_d     = idle_q;
    ptr_d      = ptr_q;
    lock_err_d = 1'b0;
    case (lk_state_q)
      LK_UNLOCKED: begin
        if (accept) begin
          ptr_d = wrap_inc(grant);
          if (req_lock[grant]) begin
            lk_state_d = LK_LOCKED;
            owner_d    = grant;
            idle_d     = '0;
          end
        end
      end
      LK_LOCKED: begin
        if (accept) begin
          idle_d = '0;
          if (!req_lock[grant]) begin
            lk_state_d = LK_UNLOCKED;
            ptr_d      = wrap_inc(owner_q);
          end
        end else if (idle_q == 8'(LOCK_MAX - 1)) begin
          lk_state_d = LK_UNLOCKED;
          ptr_d      = wrap_inc(owner_q);
          idle_d     = '0;
          lock_err_d = 1'b1;
        end else begin
          idle_d = idle_q + 8'd1;
        end
      end
      default: lk_state_d = LK_UNLOCKED;
    endcase
  end

  // Response register: a new accept overwrites, otherwise a drain clears valid.
  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_sum_d   = rsp_sum_q;
    rsp_id_d    = rsp_id_q;
    if (accept) begin
      rsp_valid_d = 1'b1;
      rsp_sum_d   = add_sum;
      rsp_id_d    = grant;
    end else if (rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lk_state_q  <= LK_UNLOCKED;
      owner_q     <= '0;
      idle_q      <= '0;
      ptr_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_sum_q   <= '0;
      rsp_id_q    <= '0;
      lock_err_q  <= 1'b0;
    end else begin
      lk_state_q  <= lk_state_d;
      owner_q     <= owner_d;
      idle_q      <= idle_d;
      ptr_q       <= ptr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_sum_q   <= rsp_sum_d;
      rsp_id_q    <= rsp_id_d;
      lock_err_q  <= lock_err_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_sum   = rsp_sum_q;
  assign rsp_id    = rsp_id_q;
  assign lock_err  = lock_err_q;

endmodule

// File: tb/tb_ppa_arb.sv
// Scoreboard bench for ppa_arb: cycle-level reference model pushes expected results, monitor pops.
module tb_ppa_arb;

  localparam int NREQ     = 4;
  localparam int IDW      = 2;
  localparam int LOCK_MAX = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NREQ-1:0]   req_valid = '0;
  logic [NREQ-1:0]   req_ready;
  logic [7*NREQ-1:0] req_a = '0;
  logic [7*NREQ-1:0] req_b = '0;
  logic [NREQ-1:0]   req_cin = '0;
  logic [NREQ-1:0]   req_lock = '0;
  logic              rsp_valid;
  logic              rsp_ready = 1'b0;
  logic [6:0]        rsp_sum;
  logic [IDW-1:0]    rsp_id;
  logic              lock_err;

  always #5 clk = ~clk;

  ppa_arb #(.NREQ(NREQ), .IDW(IDW), .LOCK_MAX(LOCK_MAX)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_cin   (req_cin),
    .req_lock  (req_lock),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_sum   (rsp_sum),
    .rsp_id    (rsp_id),
    .lock_err  (lock_err)
  );

  typedef struct packed {
    logic [6:0]     sum;
    logic [IDW-1:0] id;
  } rsp_t;

  rsp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   errs_obs = 0;
  bit   started  = 1'b0;

  // Reference model state
  int   m_ptr = 0;
  bit   m_locked = 1'b0;
  int   m_owner = 0;
  int   m_idle = 0;
  bit   m_pending = 1'b0;
  bit   m_err_prev = 1'b0;

  // Operands staged for the next driven cycle
  int              st_a[NREQ];
  int              st_b[NREQ];
  logic [NREQ-1:0] st_cin = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, expv);
  endtask

  task automatic rand_ops();
    for (int i = 0; i < NREQ; i++) begin
      st_a[i]   = int'($urandom_range(0, 127));
      st_b[i]   = int'($urandom_range(0, 127));
      st_cin[i] = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic cycle(input logic [NREQ-1:0] v, input logic [NREQ-1:0] lk,
                       input logic rr, input logic rn);
    int cand;
    bit acc;
    @(negedge clk);
    rst_n     = rn;
    req_valid = v;
    req_lock  = lk;
    rsp_ready = rr;
    for (int i = 0; i < NREQ; i++) begin
      req_a[7*i +: 7] = 7'(st_a[i]);
      req_b[7*i +: 7] = 7'(st_b[i]);
    end
    req_cin = st_cin;
    #1;
    if (started) begin
      chk("lock_err", {31'b0, lock_err}, {31'b0, m_err_prev});
      if (lock_err === 1'b1) errs_obs++;
    end
    if (!rn) begin
      m_ptr = 0; m_locked = 0; m_owner = 0; m_idle = 0;
      m_pending = 0; m_err_prev = 0;
      exp_q.delete();
      started = 1'b1;
      return;
    end
    cand = -1;
    if (m_locked) begin
      if (v[m_owner]) cand = m_owner;
    end else begin
      for (int k = 0; k < NREQ; k++) begin
        int j;
        j = (m_ptr + k) % NREQ;
        if (cand < 0 && v[j]) cand = j;
      end
    end
    acc = (cand >= 0) && (!m_pending || rr);
    chk("req_ready", {28'b0, req_ready}, acc ? (32'd1 << cand) : 32'd0);
    m_err_prev = 1'b0;
    if (acc) begin
      exp_q.push_back('{sum: 7'((st_a[cand] + st_b[cand] + int'(st_cin[cand])) % 128),
                        id: IDW'(cand)});
      m_pending = 1'b1;
      if (lk[cand]) begin
        m_locked = 1'b1; m_owner = cand; m_idle = 0;
      end else begin
        m_locked = 1'b0; m_ptr = (cand + 1) % NREQ;
      end
    end else begin
      if (rr) m_pending = 1'b0;
      if (m_locked) begin
        m_idle++;
        if (m_idle == LOCK_MAX) begin
          m_locked = 1'b0; m_idle = 0; m_err_prev = 1'b1;
          m_ptr = (m_owner + 1) % NREQ;
        end
      end
    end
  endtask

  // Monitor: pops an expectation whenever a response is handed over, and checks held responses.
  initial begin
    rsp_t           e;
    logic           hold;
    logic [6:0]     h_sum;
    logic [IDW-1:0] h_id;
    hold = 1'b0; h_sum = '0; h_id = '0;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n || !started) begin
        hold = 1'b0;
      end else begin
        if (hold) begin
          chk("hold_valid", {31'b0, rsp_valid}, 32'd1);
          chk("hold_sum", {25'b0, rsp_sum}, {25'b0, h_sum});
          chk("hold_id", {30'b0, rsp_id}, {30'b0, h_id});
        end
        hold  = (rsp_valid === 1'b1) && !rsp_ready;
        h_sum = rsp_sum;
        h_id  = rsp_id;
        if (rsp_valid === 1'b1 && rsp_ready) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL rsp_unexpected: got id %0d sum %0h expected no response", rsp_id, rsp_sum);
          end else begin
            e = exp_q.pop_front();
            chk("rsp_sum", {25'b0, rsp_sum}, {25'b0, e.sum});
            chk("rsp_id", {30'b0, rsp_id}, {30'b0, e.id});
          end
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < NREQ; i++) begin st_a[i] = 0; st_b[i] = 0; end

    cycle('0, '0, 1'b1, 1'b0);
    cycle('0, '0, 1'b1, 1'b0);
    cycle('0, '0, 1'b1, 1'b1);
    chk("rst_valid", {31'b0, rsp_valid}, 32'd0);
    chk("rst_sum", {25'b0, rsp_sum}, 32'd0);
    chk("rst_id", {30'b0, rsp_id}, 32'd0);
    chk("rst_lock_err", {31'b0, lock_err}, 32'd0);

    // Single request from requester 2
    st_a[2] = 'h15; st_b[2] = 'h0A; st_cin[2] = 1'b1;
    cycle(4'b0100, '0, 1'b1, 1'b1);
    cycle('0, '0, 1'b1, 1'b1);
    chk("single_sum", {25'b0, rsp_sum}, 32'h20);
    chk("single_id", {30'b0, rsp_id}, 32'd2);
    chk("single_valid", {31'b0, rsp_valid}, 32'd1);
    cycle('0, '0, 1'b1, 1'b1);
    chk("single_pulse", {31'b0, rsp_valid}, 32'd0);

    // Fairness with every requester valid
    for (int c = 0; c < 8; c++) begin rand_ops(); cycle(4'b1111, '0, 1'b1, 1'b1); end

    // Backpressure then release
    for (int c = 0; c < 3; c++) begin rand_ops(); cycle(4'b1111, '0, 1'b0, 1'b1); end
    for (int c = 0; c < 3; c++) begin rand_ops(); cycle(4'b1111, '0, 1'b1, 1'b1); end
    cycle('0, '0, 1'b1, 1'b1);

    // Sum wrap
    st_a[0] = 'h7F; st_b[0] = 'h01; st_cin[0] = 1'b1;
    cycle(4'b0001, '0, 1'b1, 1'b1);
    cycle('0, '0, 1'b1, 1'b1);
    chk("wrap_sum", {25'b0, rsp_sum}, 32'h01);

    // Locked burst by requester 1 while 0 and 3 compete
    rand_ops(); cycle(4'b0001, '0, 1'b1, 1'b1);
    rand_ops(); cycle(4'b1011, 4'b0010, 1'b1, 1'b1);
    rand_ops(); cycle(4'b1011, 4'b0010, 1'b1, 1'b1);
    rand_ops(); cycle(4'b1011, 4'b0000, 1'b1, 1'b1);
    rand_ops(); cycle(4'b1001, '0, 1'b1, 1'b1);
    rand_ops(); cycle(4'b1001, '0, 1'b1, 1'b1);
    cycle('0, '0, 1'b1, 1'b1);

    // Lock timeout: owner vanishes, requester 0 waits
    errs_obs = 0;
    rand_ops(); cycle(4'b0010, 4'b0010, 1'b1, 1'b1);
    for (int c = 0; c < 7; c++) begin rand_ops(); cycle(4'b0001, '0, 1'b1, 1'b1); end
    chk("timeout_pulses", errs_obs, 32'd1);

    // Owner accept lands on the timeout cycle: no error
    errs_obs = 0;
    rand_ops(); cycle(4'b0010, 4'b0010, 1'b1, 1'b1);
    for (int c = 0; c < 3; c++) cycle(4'b0010, 4'b0010, 1'b0, 1'b1);
    rand_ops(); cycle(4'b0010, 4'b0000, 1'b1, 1'b1);
    cycle('0, '0, 1'b1, 1'b1);
    cycle('0, '0, 1'b1, 1'b1);
    chk("coincide_pulses", errs_obs, 32'd0);

    // Reset with a lock held and a response pending
    rand_ops(); cycle(4'b0100, 4'b0100, 1'b0, 1'b1);
    cycle(4'b0100, 4'b0100, 1'b0, 1'b1);
    cycle(4'b1111, '0, 1'b0, 1'b0);
    cycle('0, '0, 1'b1, 1'b1);
    chk("midrst_valid", {31'b0, rsp_valid}, 32'd0);
    rand_ops(); cycle(4'b1111, '0, 1'b1, 1'b1);

    // Randomized traffic
    for (int c = 0; c < 600; c++) begin
      logic [NREQ-1:0] v, lk;
      logic            rr;
      rand_ops();
      v  = NREQ'($urandom_range(0, 15));
      lk = ($urandom_range(0, 3) == 0) ? NREQ'($urandom_range(0, 15)) : '0;
      rr = ($urandom_range(0, 3) != 0);
      cycle(v, lk, rr, 1'b1);
    end

    for (int c = 0; c < 4; c++) cycle('0, '0, 1'b1, 1'b1);
    chk("queue_empty", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
